divu_seq: RTL and testbench

Iterative 64-bit unsigned divider controller for the execute stage. It sequences the existing unsigned less-than comparator (`SLTU`) through a restoring-division loop, one quotient bit per cycle. It serves DIVU/REMU with a start/done handshake, and the pipeline stalls on `busy`. Divide-by-zero follows the RISC-V convention.

---
 rtl/divu_pkg.sv | 21 ++
 rtl/divu_step.sv | 34 +++
 rtl/sltu.sv | 12 +
 rtl/divu_seq.sv | 98 +++++++++
 tb/tb_divu_seq.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/divu_pkg.sv
// Shared constants and state encoding for the iterative unsigned divider.
package divu_pkg;

    localparam int unsigned DIVU_XLEN  = 64;
    localparam int unsigned DIVU_ITERS = 64;
    localparam int unsigned DIVU_CNT_W = 6;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_RUN  = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = STATE_IDLE,
        S_RUN  = STATE_RUN,
        S_DONE = STATE_DONE
    } divu_state_e;

    // Quotient returned for a zero divisor
    localparam logic [DIVU_XLEN-1:0] DIVU_DBZ_QUOT = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/divu_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare, conditionally subtract.
module divu_step
    import divu_pkg::*;
(
    input  logic [DIVU_XLEN-1:0] r,
    input  logic                 q_msb,
    input  logic [DIVU_XLEN-1:0] d,
    output logic [DIVU_XLEN-1:0] r_next,
    output logic                 ge
);

    logic [DIVU_XLEN-1:0] s;
    logic [DIVU_XLEN-1:0] diff;
    logic [DIVU_XLEN-1:0] slt_res;
    logic                 c;
    logic                 unused_slt_hi;

    assign s = {r[DIVU_XLEN-2:0], q_msb};
    assign c = r[DIVU_XLEN-1];

    sltu #(.W(DIVU_XLEN)) u_sltu (
        .a      (s),
        .b      (d),
        .result (slt_res)
    );

    assign unused_slt_hi = ^slt_res[DIVU_XLEN-1:1];

    // The shifted-out carry makes the partial remainder a 65-bit value that always covers D
    assign diff   = s - d;
    assign ge     = c | ~slt_res[0];
    assign r_next = ge ? diff : s;

endmodule

// File: rtl/sltu.sv
// Unsigned set-less-than comparator; result bit 0 holds a < b, upper bits zero.
module sltu #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result
);

    assign result = {{(W-1){1'b0}}, (a < b)};

endmodule

// File: rtl/divu_seq.sv
// Sequential 64-bit unsigned divider: start/done handshake, one quotient bit per cycle.
module divu_seq
    import divu_pkg::*;
#(
    parameter int unsigned XLEN = DIVU_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_by_zero
);

    divu_state_e           state;
    logic [XLEN-1:0]       r_reg;
    logic [XLEN-1:0]       q_reg;
    logic [XLEN-1:0]       d_reg;
    logic [DIVU_CNT_W-1:0] cnt;

    logic [XLEN-1:0]       r_next;
    logic [XLEN-1:0]       q_next;
    logic                  ge;

    divu_step u_step (
        .r      (r_reg),
        .q_msb  (q_reg[XLEN-1]),
        .d      (d_reg),
        .r_next (r_next),
        .ge     (ge)
    );

    assign q_next = {q_reg[XLEN-2:0], ge};

    // Control FSM, iteration registers and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            r_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            cnt         <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            quotient    <= DIVU_DBZ_QUOT;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state       <= S_RUN;
                            d_reg       <= divisor;
                            q_reg       <= dividend;
                            r_reg       <= '0;
                            cnt         <= DIVU_CNT_W'(DIVU_ITERS - 1);
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    if (cnt == '0) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next;
                    end else begin
                        cnt <= cnt - DIVU_CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divu_seq.sv
// Directed-vector bench for divu_seq: latency, results, divide-by-zero, ignored starts and mid-run reset.
module tb_divu_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;

    int n_cmp;
    int n_err;

    divu_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges after the current sample point until done is seen (bounded)
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Present one start, return sampled 1 time unit after the acceptance edge
    task automatic issue(input logic [63:0] dd, input logic [63:0] dv);
        @(negedge clk);
        start = 1'b1; dividend = dd; divisor = dv;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_div(input string name, input logic [63:0] dd, input logic [63:0] dv,
                           input int exp_lat, input logic [63:0] exp_q,
                           input logic [63:0] exp_r, input logic exp_dbz);
        int lat;
        issue(dd, dv);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
        end
        wait_done(lat);
        n_cmp++;
        if (lat !== exp_lat) begin
            n_err++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (quotient !== exp_q) begin
            n_err++; $display("FAIL %s quotient: got %h want %h", name, quotient, exp_q);
        end
        n_cmp++;
        if (remainder !== exp_r) begin
            n_err++; $display("FAIL %s remainder: got %h want %h", name, remainder, exp_r);
        end
        n_cmp++;
        if (div_by_zero !== exp_dbz) begin
            n_err++; $display("FAIL %s div_by_zero: got %b want %b", name, div_by_zero, exp_dbz);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL %s busy_in_done: got %b want 1", name, busy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++; $display("FAIL %s idle_after_done: got busy,done=%b want 00", name, {busy, done});
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags: got %b want 000", {busy, done, div_by_zero});
        end
        n_cmp++;
        if ({quotient, remainder} !== 128'd0) begin
            n_err++; $display("FAIL reset_results: got %h/%h want 0/0", quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        run_div("div_100_7", 64'd100, 64'd7, 64, 64'd14, 64'd2, 1'b0);
    endtask

    task automatic test_div_zero;
        run_div("div_5_0", 64'd5, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1);
    endtask

    task automatic test_boundaries;
        run_div("carry_path", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64,
                64'd1, 64'h7FFF_FFFF_FFFF_FFFE, 1'b0);
        run_div("max_by_one", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64,
                64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        run_div("small_by_big", 64'd3, 64'h8000_0000_0000_0000, 64, 64'd0, 64'd3, 1'b0);
    endtask

    task automatic test_ignored_start_and_back_to_back;
        int lat;
        issue(64'd100, 64'd7);
        lat = 0;
        while (!done && lat < 200) begin
            if (lat == 10) begin
                start = 1'b1; dividend = 64'd9; divisor = 64'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat !== 64) begin
            n_err++; $display("FAIL ignore latency: got %0d want 64", lat);
        end
        n_cmp++;
        if ({quotient, remainder} !== {64'd14, 64'd2}) begin
            n_err++; $display("FAIL ignore_run result: got %0d/%0d want 14/2", quotient, remainder);
        end
        // start in the done cycle must not be taken
        start = 1'b1; dividend = 64'd9; divisor = 64'd3;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++; $display("FAIL ignore_done state: got busy,done=%b want 00", {busy, done});
        end
        n_cmp++;
        if ({quotient, remainder} !== {64'd14, 64'd2}) begin
            n_err++; $display("FAIL ignore_done result: got %0d/%0d want 14/2", quotient, remainder);
        end
        // still high in the following IDLE cycle: accepted
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL b2b accept: got busy=%b want 1", busy);
        end
        wait_done(lat);
        n_cmp++;
        if (lat !== 64) begin
            n_err++; $display("FAIL b2b latency: got %0d want 64", lat);
        end
        n_cmp++;
        if ({quotient, remainder} !== {64'd3, 64'd0}) begin
            n_err++; $display("FAIL b2b result: got %0d/%0d want 3/0", quotient, remainder);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset;
        int done_seen;
        int busy_seen;
        issue(64'd100, 64'd7);
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++; $display("FAIL midrst flags: got busy,done=%b want 00", {busy, done});
        end
        n_cmp++;
        if ({quotient, remainder} !== 128'd0) begin
            n_err++; $display("FAIL midrst results: got %h/%h want 0/0", quotient, remainder);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0; busy_seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
        n_cmp++;
        if (done_seen !== 0 || busy_seen !== 0) begin
            n_err++; $display("FAIL midrst no_done: got done=%0d busy=%0d cycles want 0/0", done_seen, busy_seen);
        end
        run_div("after_reset", 64'd100, 64'd7, 64, 64'd14, 64'd2, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_div_zero();
        test_boundaries();
        test_ignored_start_and_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
